lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between a pipeline request port and a word-wide
// synchronous data RAM. Sub-word stores are performed as read-modify-write.
// Loads select and extend the addressed byte or half-word.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half
// and word accesses fault instead of being silently aligned.
module lsu_ctrl #(
    parameter int unsigned RAM_AW = 9
) (
    input  logic        clk0,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_wen_n,
    output logic [2:0]  ram_mem_op,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DATA,
        WR,
        RSP
    } state_t;

    // Word-address mask; the shifted byte address is ANDed with this so the
    // RAM address is zero-extended beyond RAM_AW bits.
    localparam logic [31:0] WORD_MASK = 32'((64'd1 << RAM_AW) - 64'd1);

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        ram_wen_n_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_din_q;
    logic        we_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic [1:0]  size_d;
    logic        illegal_d;
    logic        misalign_d;
    logic        fault_d;
    logic [31:0] addr_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign ram_wen_n  = ram_wen_n_q;
    assign ram_mem_op = 3'b010;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;

    // Request decode: legality, alignment and the effective byte address.
    always_comb begin
        size_d     = req_op[1:0];
        illegal_d  = (req_op == 3'b011) || (req_op == 3'b110) ||
                     (req_op == 3'b111) || (req_we && req_op[2]);
        misalign_d = ((size_d == 2'b01) && req_addr[0]) ||
                     ((size_d == 2'b10) && (req_addr[1:0] != 2'b00));
        addr_d     = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        fault_d    = illegal_d || misalign_d;
`else
        fault_d    = illegal_d;
        if (misalign_d) begin
            if (size_d == 2'b01) begin
                addr_d[0] = 1'b0;
            end else begin
                addr_d[1:0] = '0;
            end
        end
`endif
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        byte_d  = ram_dout[{off_q, 3'b000} +: 8];
        half_d  = ram_dout[{off_q[1], 4'b0000} +: 16];
        case (op_q)
            3'b000:  load_d = {{24{byte_d[7]}}, byte_d};
            3'b100:  load_d = {24'b0, byte_d};
            3'b001:  load_d = {{16{half_d[15]}}, half_d};
            3'b101:  load_d = {16'b0, half_d};
            default: load_d = ram_dout;
        endcase
        merge_d = ram_dout;
        if (op_q[1:0] == 2'b00) begin
            merge_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_d[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Access sequencer with registered handshake, RAM and response outputs.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            ram_wen_n_q <= 1'b1;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            we_q        <= 1'b0;
            op_q        <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            ram_wen_n_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        op_q        <= req_op;
                        off_q       <= addr_d[1:0];
                        wdata_q     <= req_wdata[15:0];
                        if (fault_d) begin
                            state_q     <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            ram_addr_q <= {2'b00, addr_d[31:2]} & WORD_MASK;
                            if (req_we && (size_d == 2'b10)) begin
                                state_q     <= WR;
                                ram_wen_n_q <= 1'b0;
                                ram_din_q   <= req_wdata;
                            end else begin
                                state_q <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    state_q <= DATA;
                end
                DATA: begin
                    if (we_q) begin
                        state_q     <= WR;
                        ram_wen_n_q <= 1'b0;
                        ram_din_q   <= merge_d;
                    end else begin
                        state_q     <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_d;
                        rsp_err_q   <= 1'b0;
                    end
                end
                WR: begin
                    state_q     <= RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                RSP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// traffic checked against a word-array reference model.
module tb_lsu_ctrl;

    logic        clk0 = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_wen_n;
    logic [2:0]  ram_mem_op;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt = 0;

    logic [31:0] tb_mem [512];
    logic [31:0] model_mem [512];
    int unsigned wr_count = 0;
    int unsigned memop_bad = 0;
    logic        bd_en = 1'b0;
    logic [8:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    lsu_ctrl #(.RAM_AW(9)) dut (
        .clk0(clk0), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_wen_n(ram_wen_n), .ram_mem_op(ram_mem_op), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk0 = ~clk0;

    // Synchronous single-port RAM with registered read and a backdoor port.
    always @(posedge clk0) begin
        if (ram_wen_n === 1'b0) begin
            tb_mem[ram_addr[8:0]] <= ram_din;
            wr_count <= wr_count + 1;
        end else if (bd_en) begin
            tb_mem[bd_idx] <= bd_val;
        end
        ram_dout <= tb_mem[ram_addr[8:0]];
        if (ram_mem_op !== 3'b010) memop_bad <= memop_bad + 1;
    end

    // ---------------- reference model ----------------
    function automatic bit model_fault(input bit we, input logic [2:0] op, input logic [31:0] a);
        bit illegal;
        illegal = (op == 3) || (op == 6) || (op == 7) || (we && op >= 4);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((op % 4) == 1 && (a % 2) != 0) return 1'b1;
        if ((op % 4) == 2 && (a % 4) != 0) return 1'b1;
`endif
        return illegal;
    endfunction

    function automatic int unsigned eff_addr(input logic [2:0] op, input logic [31:0] a);
        int unsigned x;
        x = a % 2048;
        if ((op % 4) == 1) x = x - (x % 2);
        if ((op % 4) == 2) x = x - (x % 4);
        return x;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
        int unsigned ea, w, b, h;
        int signed v;
        ea = eff_addr(op, a);
        w  = model_mem[ea / 4];
        b  = (w >> (8 * (ea % 4))) % 256;
        h  = (w >> (16 * ((ea % 4) / 2))) % 65536;
        case (op)
            3'd0: begin v = int'(b); if (v >= 128) v = v - 256; return 32'(v); end
            3'd4: return 32'(b);
            3'd1: begin v = int'(h); if (v >= 32768) v = v - 65536; return 32'(v); end
            3'd5: return 32'(h);
            default: return 32'(w);
        endcase
    endfunction

    task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int unsigned ea, sh;
        logic [31:0] w, mask;
        ea = eff_addr(op, a);
        w  = model_mem[ea / 4];
        if (op == 0) begin
            sh = 8 * (ea % 4);
            mask = 32'hFF << sh;
            w = (w & ~mask) | ((d & 32'hFF) << sh);
        end else if (op == 1) begin
            sh = 16 * ((ea % 4) / 2);
            mask = 32'hFFFF << sh;
            w = (w & ~mask) | ((d & 32'hFFFF) << sh);
        end else begin
            w = d;
        end
        model_mem[ea / 4] = w;
    endtask

    function automatic int unsigned model_lat(input bit we, input logic [2:0] op, input logic [31:0] a);
        if (model_fault(we, op, a)) return 1;
        if (!we) return 3;
        if (op == 2) return 2;
        return 4;
    endfunction

    // ---------------- drivers ----------------
    task automatic backdoor(input int unsigned idx, input logic [31:0] val);
        @(negedge clk0);
        bd_en = 1'b1; bd_idx = 9'(idx); bd_val = val;
        @(posedge clk0); #1;
        bd_en = 1'b0;
        model_mem[idx] = val;
    endtask

    // Issues one request and records response timing/values plus the cycle after.
    task automatic run_req(input bit we, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, output bit ready_seen, output int unsigned lat,
                           output logic [31:0] rdata, output logic err, output logic nvalid,
                           output logic [31:0] nrdata, output logic nerr, output int unsigned writes);
        int unsigned w0;
        @(negedge clk0);
        w0 = wr_count;
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = a; req_wdata = d;
        ready_seen = (req_ready === 1'b1);
        @(posedge clk0); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        lat = 0; rdata = 'x; err = 'x;
        for (int i = 1; i <= 8; i++) begin
            if (rsp_valid === 1'b1) begin lat = i; break; end
            @(posedge clk0); #1;
        end
        rdata = rsp_rdata; err = rsp_err;
        @(posedge clk0); #1;
        nvalid = rsp_valid; nrdata = rsp_rdata; nerr = rsp_err;
        @(posedge clk0); #1;
        writes = wr_count - w0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b1;
        #3;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else pass_cnt++; chk_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rsp_valid); else pass_cnt++; chk_cnt++;
        if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); else pass_cnt++; chk_cnt++;
        if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", rsp_err); else pass_cnt++; chk_cnt++;
        if (ram_wen_n !== 1'b1) $display("FAIL reset_wen_n: got %b expected 1", ram_wen_n); else pass_cnt++; chk_cnt++;
        if (ram_addr !== 32'h0) $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); else pass_cnt++; chk_cnt++;
        if (ram_din !== 32'h0) $display("FAIL reset_ram_din: got %h expected 0", ram_din); else pass_cnt++; chk_cnt++;
        if (ram_mem_op !== 3'b010) $display("FAIL reset_mem_op: got %b expected 010", ram_mem_op); else pass_cnt++; chk_cnt++;
        repeat (2) @(posedge clk0);
        @(negedge clk0) rst = 1'b0;
    endtask

    task automatic test_word();
        bit rs; int unsigned lat, wr; logic [31:0] rd, nrd; logic er, nv, ne;
        run_req(1'b1, 3'd2, 32'h40, 32'hDEADBEEF, rs, lat, rd, er, nv, nrd, ne, wr);
        model_store(3'd2, 32'h40, 32'hDEADBEEF);
        if (!rs) $display("FAIL sw_ready: got 0 expected 1"); else pass_cnt++; chk_cnt++;
        if (lat !== 2) $display("FAIL sw_latency: got %0d expected 2", lat); else pass_cnt++; chk_cnt++;
        if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sw_rsp: got rdata=%h err=%b expected 0/0", rd, er); else pass_cnt++; chk_cnt++;
        if (tb_mem[16] !== 32'hDEADBEEF || wr !== 1) $display("FAIL sw_ram: got %h writes=%0d expected deadbeef writes=1", tb_mem[16], wr); else pass_cnt++; chk_cnt++;
        run_req(1'b0, 3'd2, 32'h40, 32'h0, rs, lat, rd, er, nv, nrd, ne, wr);
        if (lat !== 3) $display("FAIL lw_latency: got %0d expected 3", lat); else pass_cnt++; chk_cnt++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_data: got %h err=%b expected deadbeef/0", rd, er); else pass_cnt++; chk_cnt++;
        if (nv !== 1'b0 || nrd !== 32'hDEADBEEF) $display("FAIL lw_pulse_hold: got valid=%b rdata=%h expected 0/deadbeef", nv, nrd); else pass_cnt++; chk_cnt++;
    endtask

    task automatic test_byte_rmw();
        bit rs; int unsigned lat, wr; logic [31:0] rd, nrd; logic er, nv, ne;
        backdoor(16, 32'h11223344);
        run_req(1'b1, 3'd0, 32'h42, 32'h555555AA, rs, lat, rd, er, nv, nrd, ne, wr);
        model_store(3'd0, 32'h42, 32'h555555AA);
        if (lat !== 4) $display("FAIL sb_latency: got %0d expected 4", lat); else pass_cnt++; chk_cnt++;
        if (tb_mem[16] !== 32'h11AA3344 || wr !== 1) $display("FAIL sb_merge: got %h writes=%0d expected 11aa3344 writes=1", tb_mem[16], wr); else pass_cnt++; chk_cnt++;
        run_req(1'b1, 3'd1, 32'h40, 32'h0000BEEF, rs, lat, rd, er, nv, nrd, ne, wr);
        model_store(3'd1, 32'h40, 32'h0000BEEF);
        if (lat !== 4 || tb_mem[16] !== 32'h11AABEEF) $display("FAIL sh_merge: got lat=%0d word=%h expected 4/11aabeef", lat, tb_mem[16]); else pass_cnt++; chk_cnt++;
    endtask

    task automatic test_extension();
        bit rs; int unsigned lat, wr; logic [31:0] rd, nrd; logic er, nv, ne;
        logic [2:0] ops [4];
        logic [31:0] exps [4];
        ops  = '{3'd0, 3'd4, 3'd1, 3'd5};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF080, 32'h0000F080};
        backdoor(0, 32'h0000F080);
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, ops[i], 32'h0, 32'h0, rs, lat, rd, er, nv, nrd, ne, wr);
            if (rd !== exps[i] || lat !== 3 || er !== 1'b0)
                $display("FAIL ext_op%0d: got %h lat=%0d err=%b expected %h lat=3 err=0", ops[i], rd, lat, er, exps[i]);
            else pass_cnt++;
            chk_cnt++;
        end
    endtask

    task automatic test_misalign();
        bit rs; int unsigned lat, wr; logic [31:0] rd, nrd; logic er, nv, ne;
        backdoor(16, 32'hA1B2C3D4);
        run_req(1'b0, 3'd2, 32'h41, 32'h0, rs, lat, rd, er, nv, nrd, ne, wr);
`ifdef LSU_MISALIGN_TRAP_EN
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || wr !== 0) $display("FAIL lw_misalign: got err=%b rdata=%h lat=%0d writes=%0d expected 1/0/1/0", er, rd, lat, wr); else pass_cnt++; chk_cnt++;
`else
        if (er !== 1'b0 || rd !== 32'hA1B2C3D4 || lat !== 3 || wr !== 0) $display("FAIL lw_misalign: got err=%b rdata=%h lat=%0d writes=%0d expected 0/a1b2c3d4/3/0", er, rd, lat, wr); else pass_cnt++; chk_cnt++;
`endif
        run_req(1'b1, 3'd1, 32'h43, 32'h00007766, rs, lat, rd, er, nv, nrd, ne, wr);
        if (!model_fault(1'b1, 3'd1, 32'h43)) model_store(3'd1, 32'h43, 32'h00007766);
        if (tb_mem[16] !== model_mem[16] || lat !== model_lat(1'b1, 3'd1, 32'h43)) $display("FAIL sh_misalign: got word=%h lat=%0d expected %h lat=%0d", tb_mem[16], lat, model_mem[16], model_lat(1'b1, 3'd1, 32'h43)); else pass_cnt++; chk_cnt++;
    endtask

    task automatic test_illegal();
        bit rs; int unsigned lat, wr; logic [31:0] rd, nrd; logic er, nv, ne;
        run_req(1'b0, 3'd7, 32'h40, 32'h0, rs, lat, rd, er, nv, nrd, ne, wr);
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) $display("FAIL illegal_op7: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, er, rd); else pass_cnt++; chk_cnt++;
        if (nerr_hold_bad(nv, ne)) $display("FAIL illegal_hold: got valid=%b err=%b expected 0/1", nv, ne); else pass_cnt++; chk_cnt++;
        run_req(1'b1, 3'd4, 32'h40, 32'hFFFFFFFF, rs, lat, rd, er, nv, nrd, ne, wr);
        if (lat !== 1 || er !== 1'b1 || wr !== 0 || tb_mem[16] !== model_mem[16]) $display("FAIL illegal_store_lbu: got lat=%0d err=%b writes=%0d expected 1/1/0", lat, er, wr); else pass_cnt++; chk_cnt++;
    endtask

    function automatic bit nerr_hold_bad(input logic nv, input logic ne);
        return (nv !== 1'b0) || (ne !== 1'b1);
    endfunction

    task automatic test_reset_midflight();
        int unsigned w0, seen;
        backdoor(32, 32'hCAFEF00D);
        @(negedge clk0);
        w0 = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'd1; req_addr = 32'h82; req_wdata = 32'h00001234;
        @(posedge clk0); #1;            // accepted, now in RD
        req_valid = 1'b0;
        @(posedge clk0); #1;            // now in DATA
        rst = 1'b1;
        #1;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) $display("FAIL rst_mid_rsp: got valid=%b rdata=%h err=%b expected 0/0/0", rsp_valid, rsp_rdata, rsp_err); else pass_cnt++; chk_cnt++;
        if (ram_wen_n !== 1'b1 || ram_addr !== 32'h0 || ram_din !== 32'h0) $display("FAIL rst_mid_ram: got wen_n=%b addr=%h din=%h expected 1/0/0", ram_wen_n, ram_addr, ram_din); else pass_cnt++; chk_cnt++;
        repeat (2) @(posedge clk0);
        @(negedge clk0) rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk0); #1;
            if (rsp_valid === 1'b1) seen++;
        end
        if (seen !== 0 || wr_count - w0 !== 0) $display("FAIL rst_mid_quiet: got pulses=%0d writes=%0d expected 0/0", seen, wr_count - w0); else pass_cnt++; chk_cnt++;
        if (tb_mem[32] !== 32'hCAFEF00D) $display("FAIL rst_mid_ram_word: got %h expected cafef00d", tb_mem[32]); else pass_cnt++; chk_cnt++;
        if (req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", req_ready); else pass_cnt++; chk_cnt++;
    endtask

    task automatic test_random();
        bit rs; int unsigned lat, wr, elat, ewr, bad;
        logic [31:0] rd, nrd, a, d, erd; logic er, nv, ne, eer;
        bit we; logic [2:0] op;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 2047)) | ($urandom & 32'hFFFF_F800);
            d  = $urandom;
            eer  = model_fault(we, op, a);
            elat = model_lat(we, op, a);
            erd  = (eer || we) ? 32'h0 : model_load(op, a);
            ewr  = (!eer && we) ? 1 : 0;
            run_req(we, op, a, d, rs, lat, rd, er, nv, nrd, ne, wr);
            if (!eer && we) model_store(op, a, d);
            if (!rs || lat !== elat || rd !== erd || er !== eer || wr !== ewr)
                $display("FAIL rand%0d we=%0d op=%0d addr=%h: got rdy=%0d lat=%0d rdata=%h err=%b writes=%0d expected 1/%0d/%h/%b/%0d",
                         n, we, op, a, rs, lat, rd, er, wr, elat, erd, eer, ewr);
            else pass_cnt++;
            chk_cnt++;
            if (nv !== 1'b0 || nrd !== erd || ne !== eer)
                $display("FAIL rand%0d_hold: got valid=%b rdata=%h err=%b expected 0/%h/%b", n, nv, nrd, ne, erd, eer);
            else pass_cnt++;
            chk_cnt++;
        end
        bad = 0;
        for (int i = 0; i < 512; i++) if (tb_mem[i] !== model_mem[i]) bad++;
        if (bad !== 0) $display("FAIL ram_image: got %0d differing words expected 0", bad); else pass_cnt++; chk_cnt++;
        if (memop_bad !== 0) $display("FAIL mem_op_const: got %0d bad cycles expected 0", memop_bad); else pass_cnt++; chk_cnt++;
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 512; i++) backdoor(i, $urandom);
        test_word();
        test_byte_rmw();
        test_extension();
        test_misalign();
        test_illegal();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
